// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared FSM state type and SR command encodings for sr_cmd_gen.
package sr_cmd_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_VERIFY} state_e;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RST     = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

endpackage

// File: rtl/sr_in_cond.sv
// sr_in_cond: 2-flop synchronizer, optional debounce (SR_CMD_DEBOUNCE_EN), rising-edge pulse.
module sr_in_cond #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    output logic pulse_o
);
    logic [1:0] sync_q;
    logic       lvl;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], req_i};
            prev_q <= lvl;
        end

`ifdef SR_CMD_DEBOUNCE_EN
    logic       lvl_q;
    logic [7:0] cnt_q;

    // Counts consecutive samples that disagree with the conditioned level.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else if (sync_q[1] == lvl_q) begin
            cnt_q <= '0;
        end else if (cnt_q == 8'(DB_CYCLES - 1)) begin
            lvl_q <= sync_q[1];
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end

    assign lvl = lvl_q;
`else
    logic unused_db;
    assign unused_db = |DB_CYCLES;
    assign lvl       = sync_q[1];
`endif

    assign pulse_o = lvl & ~prev_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: conditions set/reset requests, arbitrates them and drives legal SR commands with
// feedback verification. Define SR_CMD_DEBOUNCE_EN to insert the input debouncers.
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter bit PRIO_SET  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_req,
    input  logic       rst_req,
    input  logic       q_fb,
    output logic [1:0] sr,
    output logic       busy,
    output logic       q_exp,
    output logic       conflict,
    output logic       err
);
    logic       set_edge, rst_edge;
    logic       set_pend_q, set_pend_d, rst_pend_q, rst_pend_d;
    state_e     state_q, state_d;
    logic [1:0] sr_q, sr_d;
    logic       q_exp_q, q_exp_d, conflict_q, conflict_d, err_q, err_d;
    logic       take, target;

    sr_in_cond #(.DB_CYCLES(DB_CYCLES)) u_set (
        .clk(clk), .rst_n(rst_n), .req_i(set_req), .pulse_o(set_edge)
    );

    sr_in_cond #(.DB_CYCLES(DB_CYCLES)) u_rst (
        .clk(clk), .rst_n(rst_n), .req_i(rst_req), .pulse_o(rst_edge)
    );

    always_comb begin
        take       = state_q == ST_IDLE && (set_pend_q || rst_pend_q);
        target     = set_pend_q && (PRIO_SET || !rst_pend_q);
        state_d    = state_q;
        sr_d       = SR_HOLD;
        q_exp_d    = q_exp_q;
        err_d      = err_q;
        conflict_d = take && set_pend_q && rst_pend_q;
        // A taken request clears both bits (winner consumed, loser dropped); a new edge re-arms.
        set_pend_d = (set_pend_q && !take) || set_edge;
        rst_pend_d = (rst_pend_q && !take) || rst_edge;
        case (state_q)
            ST_IDLE:
                if (take && target != q_exp_q) begin
                    state_d = ST_DRIVE;
                    sr_d    = target ? SR_SET : SR_RST;
                    q_exp_d = target;
                end
            ST_DRIVE:  state_d = ST_VERIFY;
            ST_VERIFY: begin
                state_d = ST_IDLE;
                err_d   = err_q || (q_fb != q_exp_q);
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sr_q       <= SR_HOLD;
            q_exp_q    <= 1'b0;
            conflict_q <= 1'b0;
            err_q      <= 1'b0;
            set_pend_q <= 1'b0;
            rst_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            q_exp_q    <= q_exp_d;
            conflict_q <= conflict_d;
            err_q      <= err_d;
            set_pend_q <= set_pend_d;
            rst_pend_q <= rst_pend_d;
        end

    assign sr       = sr_q;
    assign busy     = state_q != ST_IDLE;
    assign q_exp    = q_exp_q;
    assign conflict = conflict_q;
    assign err      = err_q;

    a_sr_legal: assert property (@(posedge clk) disable iff (!rst_n) sr_q != SR_ILLEGAL);

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: directed checks of sr_cmd_gen with set- and reset-priority instances side by side.
module tb_sr_cmd_gen;

`ifdef SR_CMD_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_req = 1'b0;
    logic       rst_req = 1'b0;
    logic       fb_force = 1'b0;
    logic       ff1, ff0, q_fb1, q_fb0;
    logic [1:0] sr1, sr0;
    logic       busy1, busy0, q_exp1, q_exp0, conflict1, conflict0, err1, err0;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    sr_cmd_gen #(.DB_CYCLES(4), .PRIO_SET(1'b1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .rst_req(rst_req), .q_fb(q_fb1),
        .sr(sr1), .busy(busy1), .q_exp(q_exp1), .conflict(conflict1), .err(err1)
    );

    sr_cmd_gen #(.DB_CYCLES(4), .PRIO_SET(1'b0)) u_p0 (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .rst_req(rst_req), .q_fb(q_fb0),
        .sr(sr0), .busy(busy0), .q_exp(q_exp0), .conflict(conflict0), .err(err0)
    );

    // Downstream SR flip-flops, one per instance.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ff1 <= 1'b0;
            ff0 <= 1'b0;
        end else begin
            if (sr1 == 2'b10) ff1 <= 1'b1; else if (sr1 == 2'b01) ff1 <= 1'b0;
            if (sr0 == 2'b10) ff0 <= 1'b1; else if (sr0 == 2'b01) ff0 <= 1'b0;
        end

    assign q_fb1 = ff1 & ~fb_force;
    assign q_fb0 = ff0 & ~fb_force;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        tick(2);
        chk("rst_sr", 8'(sr1), 8'h0);
        chk("rst_busy", 8'(busy1), 8'h0);
        chk("rst_qexp", 8'(q_exp1), 8'h0);
        chk("rst_conflict", 8'(conflict1), 8'h0);
        chk("rst_err", 8'(err1), 8'h0);
        rst_n = 1'b1;
        tick(2);

        // Single set: command at N+3 for one cycle, busy for two.
        set_req = 1'b1;
        tick(LAT);
        chk("set_pre", 8'(sr1), 8'h0);
        tick(1);
        chk("set_sr", 8'(sr1), 8'h2);
        chk("set_busy", 8'(busy1), 8'h1);
        chk("set_qexp", 8'(q_exp1), 8'h1);
        chk("set_sr_p0", 8'(sr0), 8'h2);
        tick(1);
        chk("set_drop", 8'(sr1), 8'h0);
        chk("set_busy2", 8'(busy1), 8'h1);
        tick(1);
        chk("set_idle", 8'(busy1), 8'h0);
        chk("set_err", 8'(err1), 8'h0);
        tick(3);
        chk("set_hold_one", 8'(sr1), 8'h0);
        set_req = 1'b0;
        tick(LAT + 2);

        // Redundant set.
        set_req = 1'b1;
        tick(LAT + 1);
        chk("redund_sr", 8'(sr1), 8'h0);
        chk("redund_busy", 8'(busy1), 8'h0);
        tick(2);
        chk("redund_busy2", 8'(busy1), 8'h0);
        chk("redund_qexp", 8'(q_exp1), 8'h1);
        set_req = 1'b0;
        tick(LAT + 2);

        // Reset request.
        rst_req = 1'b1;
        tick(LAT + 1);
        chk("reset_sr", 8'(sr1), 8'h1);
        chk("reset_sr_p0", 8'(sr0), 8'h1);
        chk("reset_qexp", 8'(q_exp1), 8'h0);
        tick(3);
        rst_req = 1'b0;
        tick(LAT + 2);

        // Simultaneous edges, both shadows at 0.
        set_req = 1'b1;
        rst_req = 1'b1;
        tick(LAT + 1);
        chk("sim_sr_p1", 8'(sr1), 8'h2);
        chk("sim_conf_p1", 8'(conflict1), 8'h1);
        chk("sim_sr_p0", 8'(sr0), 8'h0);
        chk("sim_conf_p0", 8'(conflict0), 8'h1);
        chk("sim_busy_p0", 8'(busy0), 8'h0);
        tick(1);
        chk("sim_conf_end_p1", 8'(conflict1), 8'h0);
        chk("sim_conf_end_p0", 8'(conflict0), 8'h0);
        tick(2);
        chk("sim_no_rst_sr", 8'(sr1), 8'h0);
        chk("sim_no_rst_qexp", 8'(q_exp1), 8'h1);
        set_req = 1'b0;
        rst_req = 1'b0;
        tick(LAT + 2);

        // Set alone: only the reset-priority instance needs it.
        set_req = 1'b1;
        tick(LAT + 1);
        chk("solo_sr_p1", 8'(sr1), 8'h0);
        chk("solo_sr_p0", 8'(sr0), 8'h2);
        tick(2);
        set_req = 1'b0;
        tick(LAT + 2);

        // Simultaneous edges, both shadows at 1.
        set_req = 1'b1;
        rst_req = 1'b1;
        tick(LAT + 1);
        chk("sim2_sr_p1", 8'(sr1), 8'h0);
        chk("sim2_conf_p1", 8'(conflict1), 8'h1);
        chk("sim2_sr_p0", 8'(sr0), 8'h1);
        chk("sim2_conf_p0", 8'(conflict0), 8'h1);
        chk("sim2_qexp_p0", 8'(q_exp0), 8'h0);
        tick(3);
        set_req = 1'b0;
        rst_req = 1'b0;
        tick(LAT + 2);

        // Reset edge then set edge one cycle later.
        rst_req = 1'b1;
        tick(1);
        set_req = 1'b1;
        tick(LAT);
        chk("b2b_rst_p1", 8'(sr1), 8'h1);
        chk("b2b_rst_p0", 8'(sr0), 8'h0);
        tick(1);
        chk("b2b_gap1_p1", 8'(sr1), 8'h0);
        chk("b2b_reset_clear_p0", 8'(sr0), 8'h2);
        tick(1);
        chk("b2b_gap2_p1", 8'(sr1), 8'h0);
        tick(1);
        chk("b2b_set_p1", 8'(sr1), 8'h2);
        tick(3);
        set_req = 1'b0;
        rst_req = 1'b0;
        tick(LAT + 2);

        // Feedback mismatch.
        rst_req = 1'b1;
        tick(LAT + 3);
        rst_req = 1'b0;
        tick(LAT + 2);
        chk("fb_pre_err", 8'(err1), 8'h0);
        fb_force = 1'b1;
        set_req = 1'b1;
        tick(LAT + 2);
        chk("fb_drive_err", 8'(err1), 8'h0);
        tick(1);
        chk("fb_err_p1", 8'(err1), 8'h1);
        chk("fb_err_p0", 8'(err0), 8'h1);
        set_req = 1'b0;
        fb_force = 1'b0;
        tick(LAT + 3);
        chk("fb_sticky", 8'(err1), 8'h1);

        // Asynchronous reset during DRIVE.
        rst_req = 1'b1;
        tick(LAT + 3);
        rst_req = 1'b0;
        tick(LAT + 2);
        set_req = 1'b1;
        tick(LAT + 1);
        chk("mid_sr", 8'(sr1), 8'h2);
        chk("mid_qexp", 8'(q_exp1), 8'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sr", 8'(sr1), 8'h0);
        chk("mid_rst_qexp", 8'(q_exp1), 8'h0);
        chk("mid_rst_busy", 8'(busy1), 8'h0);
        chk("mid_rst_err", 8'(err1), 8'h0);
        set_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(LAT + 2);

`ifdef SR_CMD_DEBOUNCE_EN
        n = 0;
        set_req = 1'b1;
        tick(3);
        set_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            n += (sr1 == 2'b10) ? 1 : 0;
        end
        chk("db_short", 8'(n), 8'h0);
        n = 0;
        set_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) set_req = 1'b0;
            tick(1);
            n += (sr1 == 2'b10) ? 1 : 0;
        end
        chk("db_long", 8'(n), 8'h1);
        tick(LAT + 2);
`endif

        // Random stimulus: sr must never be the illegal code.
        for (int i = 0; i < 300; i++) begin
            set_req  = 1'($urandom_range(0, 1));
            rst_req  = 1'($urandom_range(0, 1));
            fb_force = ($urandom_range(0, 7) == 0);
            tick(1);
            chk("legal_p1", 8'(sr1 == 2'b11), 8'h0);
            chk("legal_p0", 8'(sr0 == 2'b11), 8'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
